// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate between NUM_REQ managers.
// Selection and grant are combinational; a lock holds an ungranted A-phase
// stable, and an in-order ID FIFO steers each response to its issuer.
module obi_rr_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                  clk_i,
    input  logic                                  reset_ni,
    input  logic [NUM_REQ-1:0]                    req_i,
    output logic [NUM_REQ-1:0]                    gnt_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         addr_i,
    input  logic [NUM_REQ-1:0]                    we_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]       be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]         wdata_i,
    output logic [NUM_REQ-1:0]                    rvalid_o,
    input  logic [NUM_REQ-1:0]                    rready_i,
    output logic [DATA_WIDTH-1:0]                 rdata_o,
    output logic                                  err_o,
    output logic                                  obi_req_o,
    input  logic                                  obi_gnt_i,
    output logic [ADDR_WIDTH-1:0]                 obi_addr_o,
    output logic                                  obi_we_o,
    output logic [DATA_WIDTH/8-1:0]               obi_be_o,
    output logic [DATA_WIDTH-1:0]                 obi_wdata_o,
    input  logic                                  obi_rvalid_i,
    output logic                                  obi_rready_o,
    input  logic [DATA_WIDTH-1:0]                 obi_rdata_i,
    input  logic                                  obi_err_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding_o,
    output logic                                  protocol_err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BE_W  = DATA_WIDTH / 8;

    logic [IDX_W-1:0] rr_ptr_r;
    logic             lock_valid_r;
    logic [IDX_W-1:0] lock_idx_r;
    logic [IDX_W-1:0] fifo_mem_r [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             protocol_err_r;

    logic [IDX_W-1:0]   sel_s;
    logic               any_req_s;
    logic               full_s;
    logic               empty_s;
    logic               obi_req_s;
    logic               hs_s;
    logic [IDX_W-1:0]   head_s;
    logic               obi_rready_s;
    logic               pop_s;
    logic [NUM_REQ-1:0] gnt_s;
    logic [NUM_REQ-1:0] rvalid_s;

    // Pointer increment with wrap at the FIFO depth.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return PTR_W'(0);
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Round-robin pick: scan from rr_ptr upward; the held lock overrides it.
    always_comb begin
        logic [IDX_W-1:0] cand_v;
        cand_v = IDX_W'(0);
        sel_s  = rr_ptr_r;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_v = IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (req_i[cand_v]) begin
                sel_s = cand_v;
            end else begin
                sel_s = sel_s;
            end
        end
        if (lock_valid_r) begin
            sel_s = lock_idx_r;
        end else begin
            sel_s = sel_s;
        end
    end

    assign any_req_s    = lock_valid_r || (req_i != {NUM_REQ{1'b0}});
    assign full_s       = (count_r == CNT_W'(MAX_OUTSTANDING));
    assign empty_s      = (count_r == CNT_W'(0));
    assign obi_req_s    = any_req_s && !full_s;
    assign hs_s         = obi_req_s && obi_gnt_i;
    assign head_s       = fifo_mem_r[rd_ptr_r];
    assign obi_rready_s = !empty_s && rready_i[head_s];
    assign pop_s        = obi_rvalid_i && obi_rready_s;

    // A-channel payload mux and one-hot grant for the selected requester.
    always_comb begin
        obi_addr_o  = {ADDR_WIDTH{1'b0}};
        obi_we_o    = 1'b0;
        obi_be_o    = {BE_W{1'b0}};
        obi_wdata_o = {DATA_WIDTH{1'b0}};
        gnt_s       = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_s == IDX_W'(i)) begin
                obi_addr_o  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                obi_we_o    = we_i[i];
                obi_be_o    = be_i[i*BE_W +: BE_W];
                obi_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                gnt_s[i]    = hs_s;
            end else begin
                gnt_s[i] = 1'b0;
            end
        end
    end

    // Route the response valid to the requester at the FIFO head.
    always_comb begin
        rvalid_s = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!empty_s && (head_s == IDX_W'(i))) begin
                rvalid_s[i] = obi_rvalid_i;
            end else begin
                rvalid_s[i] = 1'b0;
            end
        end
    end

    // Control outputs are held low for as long as reset is asserted.
    assign obi_req_o      = reset_ni && obi_req_s;
    assign gnt_o          = {NUM_REQ{reset_ni}} & gnt_s;
    assign rvalid_o       = {NUM_REQ{reset_ni}} & rvalid_s;
    assign obi_rready_o   = reset_ni && obi_rready_s;
    assign outstanding_o  = {CNT_W{reset_ni}} & count_r;
    assign protocol_err_o = reset_ni && protocol_err_r;
    assign rdata_o        = obi_rdata_i;
    assign err_o          = obi_err_i;

    // Advance round-robin priority on a handshake; hold an ungranted request.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_ptr_r     <= IDX_W'(0);
            lock_valid_r <= 1'b0;
            lock_idx_r   <= IDX_W'(0);
        end else if (hs_s) begin
            rr_ptr_r     <= (sel_s == IDX_W'(NUM_REQ - 1)) ? IDX_W'(0) : sel_s + IDX_W'(1);
            lock_valid_r <= 1'b0;
        end else if (obi_req_s) begin
            lock_valid_r <= 1'b1;
            lock_idx_r   <= sel_s;
        end else begin
            lock_valid_r <= lock_valid_r;
        end
    end

    // In-order ID FIFO: push granted index, pop on response handshake.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem_r[i] <= IDX_W'(0);
            end
            rd_ptr_r <= PTR_W'(0);
            wr_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (hs_s) begin
                fifo_mem_r[wr_ptr_r] <= sel_s;
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({hs_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for a response arriving with no transaction outstanding.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            protocol_err_r <= 1'b0;
        end else if (obi_rvalid_i && empty_s) begin
            protocol_err_r <= 1'b1;
        end else begin
            protocol_err_r <= protocol_err_r;
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter: a vector table of per-cycle stimulus
// and expected outputs, plus hand-written response-routing and reset sequences.
module tb_obi_rr_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 2;

    logic                 clk = 1'b0;
    logic                 reset_ni = 1'b0;
    logic [NR-1:0]        req_i;
    logic [NR-1:0]        gnt_o;
    logic [NR*AW-1:0]     addr_i;
    logic [NR-1:0]        we_i;
    logic [NR*DW/8-1:0]   be_i;
    logic [NR*DW-1:0]     wdata_i;
    logic [NR-1:0]        rvalid_o;
    logic [NR-1:0]        rready_i;
    logic [DW-1:0]        rdata_o;
    logic                 err_o;
    logic                 obi_req_o;
    logic                 obi_gnt_i;
    logic [AW-1:0]        obi_addr_o;
    logic                 obi_we_o;
    logic [DW/8-1:0]      obi_be_o;
    logic [DW-1:0]        obi_wdata_o;
    logic                 obi_rvalid_i;
    logic                 obi_rready_o;
    logic [DW-1:0]        obi_rdata_i;
    logic                 obi_err_i;
    logic [1:0]           outstanding_o;
    logic                 protocol_err_o;

    always #5 clk = ~clk;

    obi_rr_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i), .be_i(be_i),
        .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rready_i(rready_i), .rdata_o(rdata_o),
        .err_o(err_o), .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
        .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
        .obi_rvalid_i(obi_rvalid_i), .obi_rready_o(obi_rready_o), .obi_rdata_i(obi_rdata_i),
        .obi_err_i(obi_err_i), .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    typedef struct {
        logic       start;
        logic [3:0] req;
        logic       gnt;
        logic       rv;
        logic [3:0] rrdy;
        logic [3:0] e_gnt;
        logic       e_oreq;
        logic [3:0] e_rv;
        logic       e_ordy;
        logic [1:0] e_out;
        logic       chk_addr;
        logic [1:0] e_sel;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [3:0] rq, input logic g, input logic rv,
                       input logic [3:0] rr, input logic [3:0] eg, input logic eo,
                       input logic [3:0] erv, input logic erd, input logic [1:0] eout,
                       input logic ca, input logic [1:0] es);
        vec_t v;
        v.start = st; v.req = rq; v.gnt = g; v.rv = rv; v.rrdy = rr;
        v.e_gnt = eg; v.e_oreq = eo; v.e_rv = erv; v.e_ordy = erd; v.e_out = eout;
        v.chk_addr = ca; v.e_sel = es;
        vecs.push_back(v);
    endtask

    task automatic idle();
        req_i = 4'b0000; obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0;
        rready_i = 4'b0000; obi_rdata_i = 32'h0; obi_err_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset_ni = 1'b0;
        @(negedge clk);
        reset_ni = 1'b1;
    endtask

    function automatic logic [31:0] exp_addr(input logic [1:0] s);
        return 32'h1000_0000 + {22'd0, s, 8'h00};
    endfunction

    initial begin
        addr_i  = {32'h1000_0300, 32'h1000_0200, 32'h1000_0100, 32'h1000_0000};
        we_i    = 4'b1010;
        be_i    = 16'hF731;
        wdata_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        idle();

        // single requester
        add(1'b1, 4'b0010, 1'b1, 1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd1);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 2'd0);
        add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0);
        // round robin 0,1,2,3,0
        add(1'b1, 4'b1111, 1'b1, 1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd0);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 4'b0010, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b1, 2'd1);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 4'b0100, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 2'd2);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 4'b1000, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1, 2'd3);
        add(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 4'b0001, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1, 2'd0);
        // lock on requester 2 while requester 0 arrives
        add(1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd2);
        add(1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd2);
        add(1'b0, 4'b0101, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd2);
        add(1'b0, 4'b0101, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd2);
        add(1'b0, 4'b0101, 1'b1, 1'b1, 4'b0100, 4'b0001, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1, 2'd0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd1, 1'b0, 2'd0);
        // FIFO full, pop does not unblock the same cycle
        add(1'b1, 4'b0011, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 2'd0);
        add(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 2'd1);
        add(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 2'd0);
        add(1'b0, 4'b0011, 1'b1, 1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd2, 1'b1, 2'd0);
        add(1'b0, 4'b0011, 1'b1, 1'b0, 4'b0011, 4'b0001, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 2'd0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd2, 1'b0, 2'd0);
        add(1'b0, 4'b0000, 1'b0, 1'b1, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd1, 1'b0, 2'd0);

        // reset state
        #3;
        chk("rst_oreq", obi_req_o, 1'b0);
        chk("rst_gnt", gnt_o, 4'b0000);
        chk("rst_rvalid", rvalid_o, 4'b0000);
        chk("rst_out", outstanding_o, 2'd0);
        chk("rst_perr", protocol_err_o, 1'b0);
        @(negedge clk);
        reset_ni = 1'b1;

        // vector table
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].start) do_reset();
            @(negedge clk);
            req_i        = vecs[i].req;
            obi_gnt_i    = vecs[i].gnt;
            obi_rvalid_i = vecs[i].rv;
            rready_i     = vecs[i].rrdy;
            obi_rdata_i  = 32'hA000_0000 + i;
            #2;
            chk($sformatf("v%0d_gnt", i), gnt_o, vecs[i].e_gnt);
            chk($sformatf("v%0d_oreq", i), obi_req_o, vecs[i].e_oreq);
            chk($sformatf("v%0d_rvalid", i), rvalid_o, vecs[i].e_rv);
            chk($sformatf("v%0d_ordy", i), obi_rready_o, vecs[i].e_ordy);
            chk($sformatf("v%0d_out", i), outstanding_o, vecs[i].e_out);
            if (vecs[i].chk_addr) begin
                chk($sformatf("v%0d_addr", i), obi_addr_o, exp_addr(vecs[i].e_sel));
                chk($sformatf("v%0d_we", i), obi_we_o, (vecs[i].e_sel == 2'd1) || (vecs[i].e_sel == 2'd3));
            end
            if (vecs[i].e_rv != 4'b0000) begin
                chk($sformatf("v%0d_rdata", i), rdata_o, 32'hA000_0000 + i);
            end
        end

        // response routing: grant 3 then 1, stall requester 3 for two cycles
        do_reset();
        @(negedge clk); req_i = 4'b1000; obi_gnt_i = 1'b1; #2;
        chk("rt_gnt3", gnt_o, 4'b1000);
        @(negedge clk); req_i = 4'b0010; #2;
        chk("rt_gnt1", gnt_o, 4'b0010);
        @(negedge clk); idle(); obi_rvalid_i = 1'b1; obi_rdata_i = 32'h11; rready_i = 4'b0111;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk("rt_stall_rv", rvalid_o, 4'b1000);
            chk("rt_stall_rdy", obi_rready_o, 1'b0);
            chk("rt_stall_out", outstanding_o, 2'd2);
            @(negedge clk);
        end
        rready_i = 4'b1111; #2;
        chk("rt_r3_rv", rvalid_o, 4'b1000);
        chk("rt_r3_rdy", obi_rready_o, 1'b1);
        chk("rt_r3_data", rdata_o, 32'h11);
        @(negedge clk); obi_rdata_i = 32'h22; #2;
        chk("rt_r1_rv", rvalid_o, 4'b0010);
        chk("rt_r1_data", rdata_o, 32'h22);
        chk("rt_r1_out", outstanding_o, 2'd1);
        @(negedge clk); idle(); #2;
        chk("rt_done_out", outstanding_o, 2'd0);

        // protocol error and mid-transaction reset
        do_reset();
        @(negedge clk); obi_rvalid_i = 1'b1; #2;
        chk("pe_rv_empty", rvalid_o, 4'b0000);
        chk("pe_rdy_empty", obi_rready_o, 1'b0);
        chk("pe_before", protocol_err_o, 1'b0);
        @(negedge clk); obi_rvalid_i = 1'b0; #2;
        chk("pe_set", protocol_err_o, 1'b1);
        @(negedge clk); #2;
        chk("pe_sticky", protocol_err_o, 1'b1);
        @(negedge clk); req_i = 4'b0001; obi_gnt_i = 1'b1; #2;
        chk("mr_gnt", gnt_o, 4'b0001);
        @(negedge clk); obi_gnt_i = 1'b0; rready_i = 4'b0001; obi_rvalid_i = 1'b1; #1;
        chk("mr_pre_out", outstanding_o, 2'd1);
        chk("mr_pre_oreq", obi_req_o, 1'b1);
        reset_ni = 1'b0; #1;
        chk("mr_oreq", obi_req_o, 1'b0);
        chk("mr_gnt0", gnt_o, 4'b0000);
        chk("mr_rvalid", rvalid_o, 4'b0000);
        chk("mr_ordy", obi_rready_o, 1'b0);
        chk("mr_out", outstanding_o, 2'd0);
        chk("mr_perr", protocol_err_o, 1'b0);
        @(negedge clk); idle(); reset_ni = 1'b1; #2;
        chk("mr_rel_out", outstanding_o, 2'd0);
        chk("mr_rel_perr", protocol_err_o, 1'b0);
        @(negedge clk); obi_rvalid_i = 1'b1;
        @(negedge clk); obi_rvalid_i = 1'b0; #2;
        chk("mr_late_resp", protocol_err_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
